// File: rtl/dpll_loop_filter.sv
// dpll_loop_filter -- bang-bang loop filter and DCO code generator.
//
// Integrates UP/DN phase-detector decisions into a clamped code index
// (0..MAX_IDX) using step-halving acquisition, then unit-step tracking
// with lock detection, and drives the DCO with a 129-bit thermometer code.
//
// Ports:
//   CLK       in   reference clock, decisions sampled on rising edge
//   RESET     in   asynchronous active-high reset
//   EN        in   loop enable, low forces IDLE
//   UP / DN   in   phase detector decisions (raise / lower the code)
//   code      out  [128:0] thermometer code, code[i] = (i < code_idx)
//   code_idx  out  [7:0]   binary index of the driven code
//   LOCK      out  loop locked
//   SAT       out  integrator sitting at 0 or MAX_IDX
//   state     out  [1:0] 0 IDLE, 1 ACQ, 2 TRACK, 3 LOCKED
//
// Build option: define DPLL_LF_PROP_EN to add a one-cycle proportional kick
// of P_STEP on code_idx in TRACK/LOCKED (the integrator is unaffected).

module dpll_loop_filter #(
  parameter int unsigned MAX_IDX    = 128,
  parameter int unsigned INIT_IDX   = 0,
  parameter int unsigned ACQ_STEP   = 32,
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned UNLOCK_RUN = 4,
  parameter int unsigned P_STEP     = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         EN,
  input  logic         UP,
  input  logic         DN,
  output logic [128:0] code,
  output logic [7:0]   code_idx,
  output logic         LOCK,
  output logic         SAT,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_t;

  localparam int unsigned RW = $clog2(LOCK_CNT + 1);
  localparam int unsigned UW = $clog2(UNLOCK_RUN + 1);

  localparam logic [8:0]    MAX9     = 9'(MAX_IDX);
  localparam logic [8:0]    INIT9    = 9'(INIT_IDX);
  localparam logic [6:0]    STEP7    = 7'(ACQ_STEP);
  localparam logic [RW-1:0] LOCK_N   = RW'(LOCK_CNT);
  localparam logic [UW-1:0] UNLOCK_N = UW'(UNLOCK_RUN);
  localparam logic          SAT_INIT = (INIT_IDX == 0) || (INIT_IDX == MAX_IDX);

  // Signed-safe move of base by +/-mag; 11 bits so underflow shows in bit 10.
  function automatic logic [10:0] raw_move(input logic [8:0] base,
                                           input logic [6:0] mag,
                                           input logic       neg);
    if (neg) return {2'b00, base} - {4'b0000, mag};
    else     return {2'b00, base} + {4'b0000, mag};
  endfunction

  function automatic logic move_oob(input logic [8:0] base,
                                    input logic [6:0] mag,
                                    input logic       neg);
    logic [10:0] sum;
    sum = raw_move(base, mag, neg);
    return sum[10] || (sum > {2'b00, MAX9});
  endfunction

  function automatic logic [8:0] move_val(input logic [8:0] base,
                                          input logic [6:0] mag,
                                          input logic       neg);
    logic [10:0] sum;
    sum = raw_move(base, mag, neg);
    if (sum[10])                    return '0;
    else if (sum > {2'b00, MAX9})   return MAX9;
    else                            return sum[8:0];
  endfunction

  state_t        state_q, state_d;
  dir_t          last_dir_q, last_dir_d;
  logic [8:0]    acc_q, acc_d;
  logic [6:0]    step_q, step_d;
  logic [RW-1:0] rev_cnt_q, rev_cnt_d;
  logic [UW-1:0] run_cnt_q, run_cnt_d;
  logic          lock_q, lock_d;
  logic          sat_q, sat_d;
  logic [7:0]    code_idx_q, code_idx_d;
  logic [128:0]  code_q, code_d;

  logic          is_up, is_dn, dec, rev, same, mv_oob;
  logic [6:0]    step_eff;
  logic [8:0]    acc_mv;

  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    acc_d      = acc_q;
    step_d     = step_q;
    rev_cnt_d  = rev_cnt_q;
    run_cnt_d  = run_cnt_q;
    lock_d     = lock_q;

    is_up = UP & ~DN;
    is_dn = DN & ~UP;
    dec   = is_up | is_dn;
    rev   = (is_up && last_dir_q == DIR_DN) || (is_dn && last_dir_q == DIR_UP);
    same  = (is_up && last_dir_q == DIR_UP) || (is_dn && last_dir_q == DIR_DN);

    // In ACQ a reversal halves the step before the move is applied.
    step_eff = (state_q == ACQ && rev) ? (step_q >> 1) : step_q;
    acc_mv   = move_val(acc_q, step_eff, is_dn);
    mv_oob   = move_oob(acc_q, step_eff, is_dn);

    if (!EN) begin
      state_d    = IDLE;
      acc_d      = INIT9;
      step_d     = STEP7;
      lock_d     = 1'b0;
      rev_cnt_d  = '0;
      run_cnt_d  = '0;
      last_dir_d = DIR_NONE;
    end else begin
      case (state_q)
        IDLE: state_d = ACQ;
        ACQ: begin
          if (dec) begin
            acc_d      = acc_mv;
            last_dir_d = is_up ? DIR_UP : DIR_DN;
            // A move pinned at a rail keeps the old step.
            if (!mv_oob) step_d = step_eff;
          end
          if (step_d == 7'd1) state_d = TRACK;
        end
        TRACK: begin
          if (dec) begin
            acc_d      = acc_mv;
            last_dir_d = is_up ? DIR_UP : DIR_DN;
            if (rev) begin
              rev_cnt_d = rev_cnt_q + 1'b1;
              if (rev_cnt_d == LOCK_N) begin
                state_d   = LOCKED;
                lock_d    = 1'b1;
                rev_cnt_d = '0;
              end
            end else if (same) begin
              rev_cnt_d = '0;
            end
          end
        end
        LOCKED: begin
          if (dec) begin
            acc_d      = acc_mv;
            last_dir_d = is_up ? DIR_UP : DIR_DN;
            // run_cnt is the length of the current same-direction run;
            // a reversal restarts it with the reversing decision.
            if (rev)       run_cnt_d = UW'(1);
            else if (same) run_cnt_d = run_cnt_q + 1'b1;
            if (run_cnt_d == UNLOCK_N) begin
              state_d   = TRACK;
              lock_d    = 1'b0;
              rev_cnt_d = '0;
              run_cnt_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    sat_d      = (acc_d == '0) || (acc_d == MAX9);
    code_idx_d = acc_d[7:0];
`ifdef DPLL_LF_PROP_EN
    if (EN && dec && (state_q == TRACK || state_q == LOCKED))
      code_idx_d = 8'(move_val(acc_q, 7'(P_STEP), is_dn));
`endif

    code_d = '0;
    for (int unsigned i = 0; i < 129; i++)
      code_d[i] = (i < 32'(code_idx_d));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      last_dir_q <= DIR_NONE;
      acc_q      <= INIT9;
      step_q     <= STEP7;
      rev_cnt_q  <= '0;
      run_cnt_q  <= '0;
      lock_q     <= 1'b0;
      sat_q      <= SAT_INIT;
      code_idx_q <= INIT9[7:0];
      code_q     <= (129'(1) << INIT_IDX) - 129'(1);
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      rev_cnt_q  <= rev_cnt_d;
      run_cnt_q  <= run_cnt_d;
      lock_q     <= lock_d;
      sat_q      <= sat_d;
      code_idx_q <= code_idx_d;
      code_q     <= code_d;
    end
  end

  assign code     = code_q;
  assign code_idx = code_idx_q;
  assign LOCK     = lock_q;
  assign SAT      = sat_q;
  assign state    = state_q;

endmodule

// File: tb/tb_dpll_loop_filter.sv
// Testbench for dpll_loop_filter (default parameters, default build).
module tb_dpll_loop_filter;

  localparam int MAXI  = 128;
  localparam int INIT  = 0;
  localparam int ACQ0  = 32;
  localparam int LOCKN = 16;
  localparam int RUNN  = 4;

  logic         CLK = 1'b0;
  logic         RESET, EN, UP, DN;
  logic [128:0] code;
  logic [7:0]   code_idx;
  logic         LOCK, SAT;
  logic [1:0]   state;

  int total = 0;
  int bad   = 0;

  // Reference model state: direction is +1 / -1 / 0 (none).
  int m_state, m_acc, m_step, m_last, m_rev, m_run;
  bit m_lock;

  dpll_loop_filter #(
    .MAX_IDX(128), .INIT_IDX(0), .ACQ_STEP(32),
    .LOCK_CNT(16), .UNLOCK_RUN(4), .P_STEP(2)
  ) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .UP(UP), .DN(DN),
    .code(code), .code_idx(code_idx), .LOCK(LOCK), .SAT(SAT), .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [128:0] got, input logic [128:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [128:0] therm(input int n);
    logic [128:0] t;
    t = '0;
    for (int i = 0; i < n; i++) t[i] = 1'b1;
    return t;
  endfunction

  function automatic int clampi(input int v);
    return (v < 0) ? 0 : ((v > MAXI) ? MAXI : v);
  endfunction

  task automatic model_reset();
    m_state = 0; m_acc = INIT; m_step = ACQ0;
    m_last = 0; m_rev = 0; m_run = 0; m_lock = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit up, input bit dn);
    int d, s, t;
    bit oob;
    d = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
    if (!en) begin
      model_reset();
      return;
    end
    case (m_state)
      0: m_state = 1;
      1: begin
        if (d != 0) begin
          s   = (m_last != 0 && d != m_last) ? m_step / 2 : m_step;
          t   = m_acc + d * s;
          oob = (t < 0) || (t > MAXI);
          m_acc = clampi(t);
          if (!oob) m_step = s;
          m_last = d;
        end
        if (m_step == 1) m_state = 2;
      end
      2: begin
        if (d != 0) begin
          m_acc = clampi(m_acc + d);
          if (m_last != 0 && d != m_last) begin
            m_rev++;
            if (m_rev == LOCKN) begin m_state = 3; m_lock = 1'b1; m_rev = 0; end
          end else if (d == m_last) begin
            m_rev = 0;
          end
          m_last = d;
        end
      end
      default: begin
        if (d != 0) begin
          m_acc = clampi(m_acc + d);
          if (m_last != 0 && d != m_last) m_run = 1;
          else if (d == m_last)           m_run++;
          if (m_run == RUNN) begin
            m_state = 2; m_lock = 1'b0; m_rev = 0; m_run = 0;
          end
          m_last = d;
        end
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".idx"},   129'(code_idx), 129'(m_acc));
    check({tag, ".code"},  code,           therm(m_acc));
    check({tag, ".lock"},  129'(LOCK),     129'(m_lock));
    check({tag, ".sat"},   129'(SAT),      129'((m_acc == 0) || (m_acc == MAXI)));
    check({tag, ".state"}, 129'(state),    129'(m_state));
  endtask

  task automatic cycle(input bit en, input bit up, input bit dn);
    @(negedge CLK);
    EN = en; UP = up; DN = dn;
    @(posedge CLK);
    #1;
    model_step(en, up, dn);
    check_all("step");
  endtask

  initial begin
    int tgt, r;
    bit u;

    RESET = 1'b1; EN = 1'b0; UP = 1'b0; DN = 1'b0;
    model_reset();
    #2;
    check("rst.code",  code,            '0);
    check("rst.idx",   129'(code_idx),  129'(0));
    check("rst.sat",   129'(SAT),       129'(1));
    check("rst.lock",  129'(LOCK),      129'(0));
    check("rst.state", 129'(state),     129'(0));
    @(negedge CLK);
    RESET = 1'b0;

    // Acquisition: 32,64,96 then halving down to step 1.
    cycle(1, 0, 0);
    check("acq.enter", 129'(state), 129'(1));
    cycle(1, 1, 0); check("acq.32", 129'(code_idx), 129'(32));
    cycle(1, 1, 0); check("acq.64", 129'(code_idx), 129'(64));
    cycle(1, 1, 0); check("acq.96", 129'(code_idx), 129'(96));
    cycle(1, 0, 1); check("acq.80", 129'(code_idx), 129'(80));
    cycle(1, 1, 0); check("acq.88", 129'(code_idx), 129'(88));
    cycle(1, 0, 1); check("acq.84", 129'(code_idx), 129'(84));
    cycle(1, 1, 0); check("acq.86", 129'(code_idx), 129'(86));
    cycle(1, 0, 1); check("acq.85", 129'(code_idx), 129'(85));
    check("acq.track", 129'(state), 129'(2));

    // Lock after 16 reversals.
    for (int k = 0; k < 16; k++) begin
      cycle(1, (k % 2) == 0, (k % 2) == 1);
      if (k == 14) check("lock.early", 129'(LOCK), 129'(0));
    end
    check("lock.rise",  129'(LOCK),  129'(1));
    check("lock.state", 129'(state), 129'(3));
    check("lock.code",  code,        therm(85));

    // Unlock after a run of four UPs.
    for (int k = 0; k < 4; k++) begin
      cycle(1, 1, 0);
      if (k == 2) check("unlock.early", 129'(LOCK), 129'(1));
    end
    check("unlock.lock",  129'(LOCK),     129'(0));
    check("unlock.state", 129'(state),    129'(2));
    check("unlock.idx",   129'(code_idx), 129'(89));

    // Holds change nothing.
    for (int k = 0; k < 10; k++) cycle(1, (k % 2) == 0, (k % 2) == 0);
    check("hold.idx", 129'(code_idx), 129'(89));

    // Upper rail.
    for (int k = 0; k < 38; k++) cycle(1, 1, 0);
    check("sat.127", 129'(code_idx), 129'(127));
    for (int k = 0; k < 3; k++) cycle(1, 1, 0);
    check("sat.idx",   129'(code_idx), 129'(128));
    check("sat.flag",  129'(SAT),      129'(1));
    check("sat.code",  code,           {1'b0, {128{1'b1}}});

    // Disable returns to IDLE.
    cycle(0, 1, 0);
    check("dis.state", 129'(state),    129'(0));
    check("dis.idx",   129'(code_idx), 129'(0));

    // Lower rail in ACQ: clamped move keeps the step.
    cycle(1, 0, 0);
    cycle(1, 0, 1); check("rail0.idx", 129'(code_idx), 129'(0));
    cycle(1, 1, 0); check("rail0.rev", 129'(code_idx), 129'(16));

    // Asynchronous reset mid-cycle.
    #2;
    RESET = 1'b1; EN = 1'b0; UP = 1'b0; DN = 1'b0;
    #1;
    model_reset();
    check("arst.code",  code,           '0);
    check("arst.idx",   129'(code_idx), 129'(0));
    check("arst.state", 129'(state),    129'(0));
    check("arst.sat",   129'(SAT),      129'(1));
    @(negedge CLK);
    RESET = 1'b0;

    // Closed loop against a random target with occasional noise.
    for (int trial = 0; trial < 3; trial++) begin
      cycle(0, 0, 0);
      tgt = int'($urandom_range(8, 120));
      for (int n = 0; n < 150; n++) begin
        r = int'($urandom_range(0, 31));
        u = (m_acc <= tgt);
        if (r == 0)      cycle(1, 0, 0);
        else if (r == 1) cycle(1, !u, u);
        else             cycle(1, u, !u);
      end
    end

    // Unconstrained random decisions with occasional disable.
    for (int n = 0; n < 300; n++)
      cycle($urandom_range(0, 49) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
